sdp_ram: RTL and testbench
==========================

// Module: sdp_ram
// PURPOSE
//  - Simple dual-port synchronous RAM: one write port and one read port on a single clock.
//  - 4096 x 32 by default. Used as the output capture buffer behind the Avalon read-out
//    logic, with three instances, one per output stream.
//  - The writer presents data + wraddress + wren. The reader presents rdaddress + rden and
//    samples q one cycle later.
// PARAMETERS
//  DATA_WIDTH  32    width of data and q
//  ADDR_WIDTH  12    width of rdaddress and wraddress
//  DEPTH       4096  number of words; DEPTH <= 2**ADDR_WIDTH
//  OUT_REG     0     0 = q valid 1 cycle after the read request; 1 = extra output register (2 cycles)
// PORTS
//  clock      in   1           rising-edge clock for all state
//  reset_n    in   1           asynchronous active-low reset
//  data       in   DATA_WIDTH  write data
//  wraddress  in   ADDR_WIDTH  write address
//  wren       in   1           write enable, sampled at posedge clock
//  rdaddress  in   ADDR_WIDTH  read address
//  rden       in   1           read enable, sampled at posedge clock
//  q          out  DATA_WIDTH  read data
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous assert):
//    - q and the OUT_REG pipeline register clear to 0 immediately.
//    - Memory contents are not cleared.
//    - While reset_n=0, writes are blocked and q stays 0.
//    - Deassertion is synchronised by the user; the first active edge is the first edge with reset_n=1.
//  - Write: at posedge with wren=1 and wraddress < DEPTH, mem[wraddress] <= data.
//    - wren=0 leaves memory unchanged.
//    - If wraddress >= DEPTH, the write is ignored.
//  - Read (OUT_REG=0):
//    - At posedge with rden=1, q <= mem[rdaddress]; the value is visible after that edge.
//    - Latency is 1 cycle.
//    - With rden=0, q holds its last value.
//  - Read (OUT_REG=1):
//    - The stage-1 register loads as above.
//    - q <= stage-1 on every posedge; latency is 2 cycles.
//  - Out-of-range read (rdaddress >= DEPTH) with rden=1: q <= 0.
//  - Read-during-write, same address, same edge: q returns the OLD contents.
//    - The new data is readable from the next read onward.
//  - Writes and reads to different addresses in the same cycle are fully independent.
//  - Addresses are unsigned and do not auto-increment; wrap-around is the caller's job.
//  - Power-up memory contents are undefined. Simulation models initialise memory to 0.
//  - Asserting wren and rden every cycle sustains 1 write + 1 read per cycle, with no stalls.
// TESTING
//  1. Reset: drive reset_n=0 mid-cycle -> q=0 immediately. A write attempted during
//     reset to addr 5 does not land: read addr 5 after reset still returns the pre-reset value.
//  2. Write/read: write 0xDEADBEEF @0x000 and 0x12345678 @0xFFF, then read 0x000 ->
//     q=0xDEADBEEF one edge later; read 0xFFF -> q=0x12345678.
//  3. Hold: after a read of 0xDEADBEEF, set rden=0 and rdaddress=0xFFF -> q stays 0xDEADBEEF.
//  4. Read-during-write: mem[7]=0x11111111; on the same edge, write 0x22222222 @7 and read 7
//     -> q=0x11111111. Next read of 7 -> q=0x22222222.
//  5. Streaming: write 0..99 to addr 0..99 on consecutive cycles, while reading addr n-1
//     each cycle -> q sequence matches 0..98 with 1-cycle lag (2-cycle lag when OUT_REG=1).
//  6. wren=0 with data toggling over all addresses -> no memory contents change
//     (verify by readback of 16 random addresses).

Source files
------------

// File: rtl/sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, single clock.
// Read-during-write to the same address returns the old word; optional output register.
module sdp_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 4096,
   parameter bit OUT_REG    = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] wraddress,
   input  logic                  wren,
   input  logic [ADDR_WIDTH-1:0] rdaddress,
   input  logic                  rden,
   output logic [DATA_WIDTH-1:0] q
);

   typedef struct packed {
      logic                  en;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wr_req_t;

   typedef struct packed {
      logic                  en;
      logic [ADDR_WIDTH-1:0] addr;
   } rd_req_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_s1;
   wr_req_t               wr;
   rd_req_t               rd;
   logic                  wr_ok;
   logic                  rd_ok;
   logic                  wr_go;

   assign wr = '{en: wren, addr: wraddress, data: data};
   assign rd = '{en: rden, addr: rdaddress};

   // Range checks only exist when the address space is larger than the array.
   generate
      if (DEPTH < (2 ** ADDR_WIDTH)) begin : g_part
         assign wr_ok = ({1'b0, wr.addr} < DEPTH_L);
         assign rd_ok = ({1'b0, rd.addr} < DEPTH_L);
      end else begin : g_full
         assign wr_ok = 1'b1;
         assign rd_ok = 1'b1;
      end
   endgenerate

   // Writes are blocked while reset is held; the array itself is never cleared.
   assign wr_go = wr.en & wr_ok & reset_n;

   always_ff @(posedge clock) begin
      if (wr_go) mem[wr.addr] <= wr.data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)   rd_s1 <= '0;
      else if (rd.en) rd_s1 <= rd_ok ? mem[rd.addr] : '0;
   end

   generate
      if (OUT_REG) begin : g_oreg
         logic [DATA_WIDTH-1:0] rd_s2;
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) rd_s2 <= '0;
            else          rd_s2 <= rd_s1;
         end
         assign q = rd_s2;
      end else begin : g_noreg
         assign q = rd_s1;
      end
   endgenerate

endmodule

// File: tb/tb_sdp_ram.sv
// Directed bench for sdp_ram: reference model of the RAM checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_sdp_ram;
   localparam int DW    = 32;
   localparam int AW    = 12;
   localparam int DEPTH = 4096;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [DW-1:0] data;
   logic [AW-1:0] wraddress;
   logic          wren;
   logic [AW-1:0] rdaddress;
   logic          rden;
   logic [DW-1:0] q;

   int n_checks = 0;
   int n_fail   = 0;

   sdp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(1'b0)) dut (
      .clock(clock), .reset_n(reset_n), .data(data), .wraddress(wraddress),
      .wren(wren), .rdaddress(rdaddress), .rden(rden), .q(q)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: word array with a written flag; q is the word read at the
   // last accepted read (old contents on same-address write), 0 after reset.
   bit [DW-1:0] m_mem   [DEPTH];
   bit          m_known [DEPTH];
   logic [DW-1:0] exp_q;
   bit            exp_known;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exp_q     = '0;
         exp_known = 1'b1;
      end else begin
         if (rden) begin
            if (int'(rdaddress) < DEPTH) begin
               exp_q     = m_mem[rdaddress];
               exp_known = m_known[rdaddress];
            end else begin
               exp_q     = '0;
               exp_known = 1'b1;
            end
         end
         if (wren && int'(wraddress) < DEPTH) begin
            m_mem[wraddress]   = data;
            m_known[wraddress] = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      if (exp_known) chk("model_q", q, exp_q);
   end

   function automatic logic [DW-1:0] pat(input int a);
      return (DW'(a) * 32'h9E3779B1) ^ 32'h00005A5A;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; data = '0; wraddress = '0; wren = 1'b0; rdaddress = '0; rden = 1'b0;
      tick(); tick();
      chk("reset_q", q, 32'h0);
      reset_n = 1'b1;
      tick();
      chk("post_reset_q", q, 32'h0);

      // 1. async reset and blocked write during reset
      wren = 1'b1; wraddress = 12'd5; data = 32'hA5A5A5A5; tick();
      wren = 1'b0; rden = 1'b1; rdaddress = 12'd5; tick();
      chk("pre_reset_read5", q, 32'hA5A5A5A5);
      rden = 1'b0;
      #2 reset_n = 1'b0;
      #1 chk("async_reset_q", q, 32'h0);
      wren = 1'b1; wraddress = 12'd5; data = 32'hBAD0BAD0;
      tick(); tick();
      chk("reset_hold_q", q, 32'h0);
      wren = 1'b0; reset_n = 1'b1;
      tick();
      rden = 1'b1; rdaddress = 12'd5; tick();
      chk("reset_write_blocked", q, 32'hA5A5A5A5);

      // 2. write/read at both ends of the array
      rden = 1'b0;
      wren = 1'b1; wraddress = 12'h000; data = 32'hDEADBEEF; tick();
      wraddress = 12'hFFF; data = 32'h12345678; tick();
      wren = 1'b0; rden = 1'b1; rdaddress = 12'h000; tick();
      chk("read_0x000", q, 32'hDEADBEEF);
      rdaddress = 12'hFFF; tick();
      chk("read_0xFFF", q, 32'h12345678);

      // 3. hold with rden=0
      rdaddress = 12'h000; tick();
      chk("read_0x000_again", q, 32'hDEADBEEF);
      rden = 1'b0; rdaddress = 12'hFFF; tick(); tick();
      chk("hold_q", q, 32'hDEADBEEF);

      // 4. read-during-write returns old data
      wren = 1'b1; wraddress = 12'd7; data = 32'h11111111; tick();
      data = 32'h22222222; rden = 1'b1; rdaddress = 12'd7; tick();
      chk("rdw_old", q, 32'h11111111);
      wren = 1'b0; tick();
      chk("rdw_new", q, 32'h22222222);

      // 5. streaming write n, read n-1
      for (int n = 0; n < 100; n++) begin
         wren = 1'b1; wraddress = AW'(n); data = DW'(n);
         rden = (n > 0); rdaddress = AW'(n - 1);
         tick();
         if (n > 0) chk("stream", q, DW'(n - 1));
      end
      wren = 1'b0; rden = 1'b0;

      // 6. fill, then sweep with wren=0 and toggling data, then spot-check
      for (int a = 0; a < DEPTH; a++) begin
         wren = 1'b1; wraddress = AW'(a); data = pat(a); tick();
      end
      for (int a = 0; a < DEPTH; a++) begin
         wren = 1'b0; wraddress = AW'(a); data = (a % 2 == 0) ? 32'hFFFFFFFF : 32'h0; tick();
      end
      for (int i = 0; i < 16; i++) begin
         int a;
         a = int'($urandom_range(0, DEPTH - 1));
         rden = 1'b1; rdaddress = AW'(a); tick();
         chk("wren0_readback", q, pat(a));
      end
      rden = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
